// File: rtl/deaggregator_var.sv
// rtl/deaggregator_var.sv - splits packed multi-element words into one element per cycle
//
// Purpose : accepts a packed word of up to FETCH_WIDTH elements plus a valid
//           count and order flag, then emits the valid elements one at a time.
//           The next word is popped on the same cycle as the last element of
//           the current word, so streaming has no bubbles at word boundaries.
// Ports   : clk, rst_n (async, active-low)
//           sender_data/sender_count/sender_reverse/sender_empty_n -> sender_deq
//           receiver_data/receiver_enq <- receiver_full_n
//           receiver_last (only with DEAGG_LAST_EN), busy
// Macro   : DEAGG_LAST_EN adds receiver_last, which marks the final element of each word.
module deaggregator_var #(
    parameter int DATA_WIDTH  = 9,
    parameter int FETCH_WIDTH = 5,
    parameter int CNT_WIDTH   = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
    input  logic [CNT_WIDTH-1:0]              sender_count,
    input  logic                              sender_reverse,
    input  logic                              sender_empty_n,
    output logic                              sender_deq,
    output logic [DATA_WIDTH-1:0]             receiver_data,
    input  logic                              receiver_full_n,
    output logic                              receiver_enq,
`ifdef DEAGG_LAST_EN
    output logic                              receiver_last,
`endif
    output logic                              busy
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                          state_q, state_d;
    logic [FETCH_WIDTH*DATA_WIDTH-1:0] buf_q, buf_d;
    logic [CNT_WIDTH-1:0]            cnt_q, cnt_d;
    logic                            rev_q, rev_d;
    logic [CNT_WIDTH-1:0]            idx_q, idx_d;

    logic [CNT_WIDTH-1:0]            count_clamped;
    logic [CNT_WIDTH-1:0]            sel;
    logic                            in_drain;
    logic                            is_last;

    always_comb begin
        count_clamped = (sender_count > CNT_WIDTH'(FETCH_WIDTH)) ? CNT_WIDTH'(FETCH_WIDTH)
                                                                 : sender_count;
        in_drain = (state_q == DRAIN);
        is_last  = (idx_q == cnt_q - CNT_WIDTH'(1));

        // Handshakes are gated by rst_n so nothing is pushed or popped while
        // reset is held, even though they are combinational.
        receiver_enq = rst_n & in_drain & receiver_full_n;
        sender_deq   = rst_n & sender_empty_n & (~in_drain | (receiver_enq & is_last));

        // Reverse order reads element cnt-1-idx; IDLE always shows element 0.
        if (!in_drain)  sel = '0;
        else if (rev_q) sel = cnt_q - CNT_WIDTH'(1) - idx_q;
        else            sel = idx_q;

        receiver_data = buf_q[DATA_WIDTH-1:0];
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (sel == CNT_WIDTH'(i)) receiver_data = buf_q[i*DATA_WIDTH +: DATA_WIDTH];
        end

        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        rev_d   = rev_q;
        idx_d   = idx_q;
        if (sender_deq) begin
            // Zero-count words are popped and dropped without leaving IDLE.
            buf_d   = sender_data;
            cnt_d   = count_clamped;
            rev_d   = sender_reverse;
            idx_d   = '0;
            state_d = (count_clamped != '0) ? DRAIN : IDLE;
        end else if (receiver_enq) begin
            if (is_last) state_d = IDLE;
            else         idx_d   = idx_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            rev_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            rev_q   <= rev_d;
            idx_q   <= idx_d;
        end
    end

    assign busy = in_drain;

`ifdef DEAGG_LAST_EN
    assign receiver_last = receiver_enq & is_last;
`endif

endmodule

// File: tb/tb_deaggregator_var.sv
// tb/tb_deaggregator_var.sv - directed and randomized-ready bench for deaggregator_var
module tb_deaggregator_var;

    localparam int DW = 9;
    localparam int FW = 5;
    localparam int CW = 3;

    typedef struct {
        logic [FW*DW-1:0] d;
        logic [CW-1:0]    c;
        logic             r;
    } word_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [FW*DW-1:0]  sender_data;
    logic [CW-1:0]     sender_count;
    logic              sender_reverse;
    logic              sender_empty_n;
    logic              sender_deq;
    logic [DW-1:0]     receiver_data;
    logic              receiver_full_n;
    logic              receiver_enq;
    logic              busy;
`ifdef DEAGG_LAST_EN
    logic              receiver_last;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    word_t wq[$];
    bit    rand_ready = 0;

    logic          s_deq, s_enq, s_busy, s_full, s_last;
    logic [DW-1:0] s_data;

    deaggregator_var #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sender_data     (sender_data),
        .sender_count    (sender_count),
        .sender_reverse  (sender_reverse),
        .sender_empty_n  (sender_empty_n),
        .sender_deq      (sender_deq),
        .receiver_data   (receiver_data),
        .receiver_full_n (receiver_full_n),
        .receiver_enq    (receiver_enq),
`ifdef DEAGG_LAST_EN
        .receiver_last   (receiver_last),
`endif
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Element j of a word holds base+j, or base+cnt-1-j when reversed, so the
    // delivered stream is base, base+1, ... in either order.
    function automatic word_t make_word(input int base, input int cnt, input bit rev, input int ccode);
        word_t w;
        int    n;
        n = (cnt > FW) ? FW : cnt;
        w.d = '0;
        for (int j = 0; j < FW; j++) begin
            if (j < n) w.d[j*DW +: DW] = DW'(rev ? base + n - 1 - j : base + j);
            else       w.d[j*DW +: DW] = DW'(base + j);
        end
        w.c = CW'(ccode);
        w.r = rev;
        return w;
    endfunction

    task automatic drive_sender();
        if (wq.size() > 0) begin
            sender_empty_n = 1'b1;
            sender_data    = wq[0].d;
            sender_count   = wq[0].c;
            sender_reverse = wq[0].r;
        end else begin
            sender_empty_n = 1'b0;
            sender_data    = '0;
            sender_count   = '0;
            sender_reverse = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        s_deq  = sender_deq;
        s_enq  = receiver_enq;
        s_data = receiver_data;
        s_busy = busy;
        s_full = receiver_full_n;
`ifdef DEAGG_LAST_EN
        s_last = receiver_last;
`else
        s_last = 1'b0;
`endif
        @(posedge clk);
        #1;
        if (s_deq && wq.size() > 0) void'(wq.pop_front());
        drive_sender();
        receiver_full_n = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        receiver_full_n = 1'b1;
        drive_sender();
        #12;
        n_cmp++; if (sender_deq !== 1'b0) begin n_bad++; $display("FAIL reset_deq got=%b exp=0", sender_deq); end
        n_cmp++; if (receiver_enq !== 1'b0) begin n_bad++; $display("FAIL reset_enq got=%b exp=0", receiver_enq); end
        n_cmp++; if (receiver_data !== '0) begin n_bad++; $display("FAIL reset_data got=%0d exp=0", receiver_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef DEAGG_LAST_EN
        n_cmp++; if (receiver_last !== 1'b0) begin n_bad++; $display("FAIL reset_last got=%b exp=0", receiver_last); end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_full_words();
        wq.push_back(make_word(0, 5, 0, 5));
        wq.push_back(make_word(5, 5, 0, 5));
        drive_sender();
        for (int c = 0; c <= 11; c++) begin
            tick();
            if (c == 0 || c == 11) begin
                n_cmp++; if (s_enq !== 1'b0) begin n_bad++; $display("FAIL full_enq_idle c=%0d got=%b exp=0", c, s_enq); end
                n_cmp++; if (s_deq !== (c == 0)) begin n_bad++; $display("FAIL full_deq c=%0d got=%b exp=%b", c, s_deq, c == 0); end
            end else begin
                n_cmp++; if (s_enq !== 1'b1 || s_data !== DW'(c - 1)) begin
                    n_bad++; $display("FAIL full_elem c=%0d got enq=%b data=%0d exp enq=1 data=%0d", c, s_enq, s_data, c - 1);
                end
                n_cmp++; if (s_deq !== (c == 5)) begin n_bad++; $display("FAIL full_deq c=%0d got=%b exp=%b", c, s_deq, c == 5); end
                n_cmp++; if (s_last !== ((c == 5 || c == 10) ? 1'b1 : 1'b0)) begin
`ifdef DEAGG_LAST_EN
                    n_bad++; $display("FAIL full_last c=%0d got=%b", c, s_last);
`endif
                end
            end
        end
    endtask

    task automatic test_reverse_partial();
        logic [DW-1:0] exp_d [3];
        exp_d[0] = 12; exp_d[1] = 11; exp_d[2] = 10;
        wq.push_back(make_word(10, 5, 0, 3));
        wq[0].r = 1'b1;
        drive_sender();
        tick();
        n_cmp++; if (s_deq !== 1'b1 || s_enq !== 1'b0) begin n_bad++; $display("FAIL rev_pop got deq=%b enq=%b exp deq=1 enq=0", s_deq, s_enq); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (s_enq !== 1'b1 || s_data !== exp_d[k]) begin
                n_bad++; $display("FAIL rev_elem k=%0d got enq=%b data=%0d exp enq=1 data=%0d", k, s_enq, s_data, exp_d[k]);
            end
`ifdef DEAGG_LAST_EN
            n_cmp++; if (s_last !== (k == 2)) begin n_bad++; $display("FAIL rev_last k=%0d got=%b exp=%b", k, s_last, k == 2); end
`endif
        end
        tick();
        n_cmp++; if (s_busy !== 1'b0 || s_enq !== 1'b0) begin n_bad++; $display("FAIL rev_idle got busy=%b enq=%b exp 0 0", s_busy, s_enq); end
    endtask

    task automatic test_zero_and_clamp();
        wq.push_back(make_word(99, 5, 0, 0));
        wq.push_back(make_word(20, 7, 0, 7));
        drive_sender();
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++; if (s_deq !== 1'b1 || s_enq !== 1'b0 || s_busy !== 1'b0) begin
                n_bad++; $display("FAIL zero_pop c=%0d got deq=%b enq=%b busy=%b exp 1 0 0", c, s_deq, s_enq, s_busy);
            end
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++; if (s_enq !== 1'b1 || s_data !== DW'(20 + k)) begin
                n_bad++; $display("FAIL clamp_elem k=%0d got enq=%b data=%0d exp enq=1 data=%0d", k, s_enq, s_data, 20 + k);
            end
        end
        tick();
        n_cmp++; if (s_busy !== 1'b0 || s_enq !== 1'b0) begin n_bad++; $display("FAIL clamp_idle got busy=%b enq=%b exp 0 0", s_busy, s_enq); end
    endtask

    task automatic test_random_ready();
        int            base = 0;
        int            total = 0;
        int            got = 0;
        int            cyc = 0;
        int            stall_bad = 0;
        int            order_bad = 0;
        logic [DW-1:0] exp_d = '0;
        logic          prev_hold = 1'b0;
        logic [DW-1:0] prev_data = '0;
        for (int w = 0; w < 200; w++) begin
            int n;
            bit r;
            n = $urandom_range(1, 5);
            r = 1'($urandom_range(0, 1));
            wq.push_back(make_word(base, n, r, n));
            base += n;
        end
        total = base;
        rand_ready = 1;
        drive_sender();
        while (got < total && cyc < 20000) begin
            tick();
            cyc++;
            if (prev_hold && s_data !== prev_data) stall_bad++;
            if (s_enq) begin
                if (s_data !== exp_d) begin
                    order_bad++;
                    if (order_bad == 1) $display("FAIL rand_order got=%0d exp=%0d", s_data, exp_d);
                end
                exp_d = exp_d + 1'b1;
                got++;
            end
            prev_hold = s_busy & ~s_full;
            prev_data = s_data;
        end
        rand_ready = 0;
        receiver_full_n = 1'b1;
        n_cmp++; if (got !== total) begin n_bad++; $display("FAIL rand_count got=%0d exp=%0d", got, total); end
        n_cmp++; if (order_bad !== 0) begin n_bad++; $display("FAIL rand_order_errors got=%0d exp=0", order_bad); end
        n_cmp++; if (stall_bad !== 0) begin n_bad++; $display("FAIL rand_stall_stable got=%0d exp=0", stall_bad); end
        tick();
        tick();
        n_cmp++; if (s_busy !== 1'b0) begin n_bad++; $display("FAIL rand_end_busy got=%b exp=0", s_busy); end
    endtask

    task automatic test_reset_mid_word();
        wq.push_back(make_word(30, 5, 0, 5));
        wq.push_back(make_word(40, 5, 0, 5));
        drive_sender();
        tick();
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++; if (s_enq !== 1'b1 || s_data !== DW'(30 + k)) begin
                n_bad++; $display("FAIL rst_pre k=%0d got enq=%b data=%0d exp enq=1 data=%0d", k, s_enq, s_data, 30 + k);
            end
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || receiver_enq !== 1'b0 || sender_deq !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid got busy=%b enq=%b deq=%b exp 0 0 0", busy, receiver_enq, sender_deq);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        n_cmp++; if (s_deq !== 1'b1 || s_enq !== 1'b0) begin n_bad++; $display("FAIL rst_repop got deq=%b enq=%b exp 1 0", s_deq, s_enq); end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++; if (s_enq !== 1'b1 || s_data !== DW'(40 + k)) begin
                n_bad++; $display("FAIL rst_post k=%0d got enq=%b data=%0d exp enq=1 data=%0d", k, s_enq, s_data, 40 + k);
            end
        end
    endtask

    initial begin
        receiver_full_n = 1'b1;
        test_reset();
        test_full_words();
        test_reverse_partial();
        test_zero_and_clamp();
        test_random_ready();
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/deaggregator_var.md
DEAGGREGATOR_VAR -- requirements
Module: deaggregator_var

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 9, bits per element.
REQ-002 SHALL have parameter FETCH_WIDTH, default 5, elements per sender word (>=2).
REQ-003 SHALL have parameter CNT_WIDTH, default 3, width of count and index fields; CNT_WIDTH >= clog2(FETCH_WIDTH+1).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port sender_data, input, FETCH_WIDTH*DATA_WIDTH, packed word; element i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
REQ-007 SHALL have port sender_count, input, CNT_WIDTH, number of valid elements in sender_data, qualified by sender_empty_n.
REQ-008 SHALL have port sender_reverse, input, 1, per-word order select: 0 = element 0 first, 1 = highest valid element first.
REQ-009 SHALL have port sender_empty_n, input, 1, sender word available.
REQ-010 SHALL have port sender_deq, output, 1, combinational pop of sender word.
REQ-011 SHALL have port receiver_data, output, DATA_WIDTH, current element.
REQ-012 SHALL have port receiver_full_n, input, 1, receiver can accept.
REQ-013 SHALL have port receiver_enq, output, 1, combinational push of receiver_data.
REQ-014 SHALL have port busy, output, 1, high while a captured word holds undelivered elements.

Function
REQ-015 SHALL implement states IDLE and DRAIN plus registers buf (word), cnt, rev, idx.
REQ-016 IDLE: sender_deq = sender_empty_n; on deq capture sender_data, clamped count, sender_reverse; set idx=0; go DRAIN if count>0, else stay IDLE (word discarded).
REQ-017 Count clamp: sender_count > FETCH_WIDTH SHALL be treated as FETCH_WIDTH.
REQ-018 DRAIN: receiver_enq = receiver_full_n; receiver_data = buf element idx if rev=0, element cnt-1-idx if rev=1.
REQ-019 DRAIN: on receiver_enq with idx < cnt-1, idx increments; no sender_deq.
REQ-020 DRAIN last element (idx == cnt-1) with receiver_enq: if sender_empty_n, sender_deq=1 same cycle, capture next word per REQ-016 (zero-count -> IDLE), else go IDLE.
REQ-021 Throughput: one element per cycle sustained across word boundaries with no bubble when sender_empty_n and receiver_full_n stay high.
REQ-022 Latency: first element of a word SHALL appear on receiver_data/receiver_enq the cycle after its sender_deq.
REQ-023 receiver_full_n low: receiver_enq=0, idx/receiver_data held stable.
REQ-024 In IDLE receiver_enq SHALL be 0; receiver_data SHALL be element 0 of buf (don't-care to receiver).
REQ-025 sender_deq SHALL never assert in DRAIN except per REQ-020.
REQ-026 busy SHALL equal (state == DRAIN).

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, buf=0, cnt=0, rev=0, idx=0; outputs sender_deq=0, receiver_enq=0, receiver_data=0, busy=0.
REQ-028 Reset mid-word SHALL discard undelivered elements; no sender_deq or receiver_enq until first edge after rst_n deasserts.

Configuration
REQ-029 Macro DEAGG_LAST_EN defined: SHALL add output port receiver_last (1 bit), high with receiver_enq on the final element of each word, else 0; reset value 0.
REQ-030 DEAGG_LAST_EN undefined: receiver_last port and logic SHALL be absent; all other behaviour identical.

Verification (DATA_WIDTH=9, FETCH_WIDTH=5, CNT_WIDTH=3)
REQ-031 Full words {0,1,2,3,4},{5..9}, count=5, reverse=0, receiver always ready -> 0..9 on consecutive cycles, sender_deq pulses 5 cycles apart, no bubble.
REQ-032 Word {10,11,12,13,14}, count=3, reverse=1 -> 12,11,10 then IDLE; with DEAGG_LAST_EN receiver_last high only on 10.
REQ-033 count=0 word then count=7 word {20..24} -> first dropped (one sender_deq, no enq), second yields 20..24 (clamped to 5).
REQ-034 Random receiver_full_n (50%) over 200 words with incrementing data -> receiver sequence strictly incrementing, no loss/duplicate, data stable while full_n low.
REQ-035 rst_n low for 1 cycle after 2 of 5 elements delivered -> busy=0, enq=0 immediately; next word restarts at its element 0.
